// File: rtl/audio_xfade_mux.sv
// audio_xfade_mux: selects one of N_SRC multichannel streams and crossfades
// linearly over 2^RAMP_LOG2 output samples whenever the selection changes.
module audio_xfade_mux #(
    parameter int N_SRC     = 6,
    parameter int CH        = 2,
    parameter int W         = 16,
    parameter int SEL_W     = 3,
    parameter int RAMP_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_SRC*CH*W-1:0] sample_in,
    input  logic [N_SRC-1:0]      valid_in,
    output logic [CH*W-1:0]       sample_out,
    output logic                  valid_out,
    output logic                  busy,
    output logic [SEL_W-1:0]      active_src
);
    localparam int GW = RAMP_LOG2 + 1;
    localparam int PW = W + GW;
    localparam logic [GW-1:0] FULL = GW'(1) << RAMP_LOG2;

    typedef enum logic {IDLE, FADE} state_t;

    state_t                          state;
    logic [SEL_W-1:0]                a, p, pend_idx;
    logic                            pend_v;
    logic [GW-1:0]                   g, g_new, g_old;
    logic [N_SRC-1:0][CH*W-1:0]      src, hold;
    logic signed [PW-1:0]            p_old [CH];
    logic signed [PW-1:0]            p_new [CH];
    logic                            v1, a_valid, sel_ok;
    logic [CH*W-1:0]                 mix;

    assign src        = sample_in;
    assign busy       = state == FADE;
    assign active_src = a;

    // Pass-through runs through the same pipe with full gain on the new source.
    always_comb begin
        a_valid = valid_in[a];
        sel_ok  = int'(sel) < N_SRC;
        g_new   = state == FADE ? g : FULL;
        g_old   = FULL - g_new;
        mix     = '0;
        for (int c = 0; c < CH; c++) mix[c*W +: W] = W'((p_old[c] + p_new[c]) >>> RAMP_LOG2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            a          <= '0;
            p          <= '0;
            g          <= '0;
            pend_v     <= 1'b0;
            pend_idx   <= '0;
            hold       <= '0;
            v1         <= 1'b0;
            valid_out  <= 1'b0;
            sample_out <= '0;
            for (int c = 0; c < CH; c++) begin
                p_old[c] <= '0;
                p_new[c] <= '0;
            end
        end else begin
            for (int s = 0; s < N_SRC; s++) if (valid_in[s]) hold[s] <= src[s];
            for (int c = 0; c < CH; c++) begin
                p_old[c] <= PW'($signed(hold[p][c*W +: W])) * PW'($signed({1'b0, g_old}));
                p_new[c] <= PW'($signed(src[a][c*W +: W])) * PW'($signed({1'b0, g_new}));
            end
            v1        <= a_valid;
            valid_out <= v1;
            if (v1) sample_out <= mix;
            if (state == IDLE) begin
                if (pend_v) begin
                    p      <= a;
                    a      <= pend_idx;
                    g      <= GW'(1);
                    pend_v <= 1'b0;
                    state  <= FADE;
                end else if (sel_ok && sel != a) begin
                    p     <= a;
                    a     <= sel;
                    g     <= GW'(1);
                    state <= FADE;
                end
            end else begin
                // Latest valid request wins; re-selecting the target cancels it.
                if (sel_ok) begin
                    pend_v   <= sel != a;
                    pend_idx <= sel;
                end
                if (a_valid) begin
                    g <= g + 1'b1;
                    if (g == FULL) state <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_audio_xfade_mux.sv
// tb_audio_xfade_mux: directed scoreboard bench for audio_xfade_mux
// (RAMP_LOG2=4, W=16, CH=2, N_SRC=6).
module tb_audio_xfade_mux;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  sel;
    logic [191:0] sample_in;
    logic [5:0]  valid_in;
    logic [31:0] sample_out;
    logic        valid_out, busy;
    logic [2:0]  active_src;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q [$];

    audio_xfade_mux #(.N_SRC(6), .CH(2), .W(16), .SEL_W(3), .RAMP_LOG2(4)) dut (
        .clk(clk), .rst(rst), .sel(sel), .sample_in(sample_in), .valid_in(valid_in),
        .sample_out(sample_out), .valid_out(valid_out), .busy(busy), .active_src(active_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
        end
    endtask

    function automatic logic [31:0] pk(input int l, input int r);
        return {16'(r), 16'(l)};
    endfunction

    function automatic int mixv(input int o, input int n, input int g);
        int t;
        t = (o * (16 - g) + n * g) >>> 4;
        return t;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic setsrc(input int s, input int l, input int r);
        sample_in[s*32 +: 16]      = 16'(l);
        sample_in[s*32 + 16 +: 16] = 16'(r);
    endtask

    task automatic pulse(input logic [5:0] m);
        valid_in = m;
        tick();
        valid_in = '0;
    endtask

    // Monitor: every valid_out consumes one scoreboard entry.
    always @(negedge clk) begin
        logic [31:0] e;
        if (valid_out) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out: got valid_out with %h, expected none at %0t", sample_out, $time);
            end else begin
                e = exp_q.pop_front();
                chk("out_L", int'($signed(sample_out[15:0])), int'($signed(e[15:0])));
                chk("out_R", int'($signed(sample_out[31:16])), int'($signed(e[31:16])));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected end of stimulus");
        $fatal(1);
    end

    localparam int DOWN [16] = '{937, 875, 812, 750, 687, 625, 562, 500,
                                 437, 375, 312, 250, 187, 125, 62, 0};

    initial begin
        int gi, ho_l, ho_r;
        logic [5:0] vin;
        rst = 1'b1; sel = '0; valid_in = '0; sample_in = '0;
        tick(3);
        chk("rst_sample_out", int'(sample_out), 0);
        chk("rst_valid_out", int'(valid_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_active_src", int'(active_src), 0);
        rst = 1'b0;
        tick();

        // Pass-through with latency check; other sources are ignored.
        setsrc(0, 123, -456);
        for (int k = 0; k < 2; k++) begin
            pulse(6'b000001);
            exp_q.push_back(pk(123, -456));
            chk("lat_t1", int'(valid_out), 0);
            tick();
            chk("lat_t2", int'(valid_out), 1);
            tick(2);
            pulse(6'b111110);
            tick(100);
        end
        chk("drain_pass", exp_q.size(), 0);

        // Fade down 1000 -> 0 on source-1 strobes.
        setsrc(0, 1000, 1000);
        pulse(6'b000001);
        exp_q.push_back(pk(1000, 1000));
        setsrc(1, 0, 0);
        sel = 3'd1;
        tick();
        chk("fade_busy_start", int'(busy), 1);
        chk("fade_active", int'(active_src), 1);
        for (int k = 0; k < 16; k++) begin
            if (k == 8) pulse(6'b000100);
            pulse(6'b000010);
            exp_q.push_back(pk(DOWN[k], DOWN[k]));
            if (k == 14) chk("fade_busy_mid", int'(busy), 1);
            if (k == 15) chk("fade_busy_end", int'(busy), 0);
        end
        tick(3);
        pulse(6'b000010);
        exp_q.push_back(pk(0, 0));
        tick(4);
        chk("drain_fade", exp_q.size(), 0);

        // Floor rounding: fade 1 -> 0 with old L=-1000, R=+1000.
        setsrc(1, -1000, 1000);
        pulse(6'b000010);
        exp_q.push_back(pk(-1000, 1000));
        setsrc(0, 0, 0);
        sel = 3'd0;
        tick();
        pulse(6'b000001);
        exp_q.push_back(pk(-938, 937));
        for (int g = 2; g <= 16; g++) begin
            pulse(6'b000001);
            exp_q.push_back(pk(mixv(-1000, 0, g), mixv(1000, 0, g)));
        end
        tick(4);
        chk("floor_busy", int'(busy), 0);
        chk("floor_active", int'(active_src), 0);
        chk("drain_floor", exp_q.size(), 0);

        // Pending select: 0 -> 1, then 2 and 3 requested mid-fade.
        setsrc(1, 800, -800);
        sel = 3'd1;
        tick();
        for (int g = 1; g <= 3; g++) begin
            pulse(6'b000010);
            exp_q.push_back(pk(mixv(0, 800, g), mixv(0, -800, g)));
        end
        sel = 3'd2; tick();
        sel = 3'd3; tick();
        chk("pend_not_abort", int'(active_src), 1);
        setsrc(3, -320, 320);
        for (int g = 4; g <= 16; g++) begin
            pulse(6'b000010);
            exp_q.push_back(pk(mixv(0, 800, g), mixv(0, -800, g)));
        end
        tick();
        chk("pend_busy2", int'(busy), 1);
        chk("pend_active3", int'(active_src), 3);
        for (int g = 1; g <= 16; g++) begin
            pulse(6'b001000);
            exp_q.push_back(pk(mixv(800, -320, g), mixv(-800, 320, g)));
        end
        tick(4);
        chk("pend_done_busy", int'(busy), 0);
        chk("drain_pend", exp_q.size(), 0);

        // Re-selecting the fade target cancels the pending request.
        setsrc(4, 160, 0);
        sel = 3'd4;
        tick();
        for (int g = 1; g <= 2; g++) begin
            pulse(6'b010000);
            exp_q.push_back(pk(mixv(-320, 160, g), mixv(320, 0, g)));
        end
        sel = 3'd5; tick();
        sel = 3'd4; tick();
        for (int g = 3; g <= 16; g++) begin
            pulse(6'b010000);
            exp_q.push_back(pk(mixv(-320, 160, g), mixv(320, 0, g)));
        end
        tick(4);
        chk("clr_busy", int'(busy), 0);
        chk("clr_active", int'(active_src), 4);
        chk("drain_clr", exp_q.size(), 0);

        // Select change in the same cycle as a strobe of the active source.
        setsrc(4, 77, -77);
        sel = 3'd0;
        valid_in = 6'b010000;
        tick();
        valid_in = '0;
        exp_q.push_back(pk(77, -77));
        setsrc(0, 1000, 1000);
        for (int g = 1; g <= 7; g++) begin
            pulse(6'b000001);
            exp_q.push_back(pk(mixv(77, 1000, g), mixv(-77, 1000, g)));
        end
        rst = 1'b1;
        tick();
        exp_q.delete();
        chk("mid_rst_sample", int'(sample_out), 0);
        chk("mid_rst_valid", int'(valid_out), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_active", int'(active_src), 0);
        tick();
        chk("mid_rst_valid2", int'(valid_out), 0);
        rst = 1'b0;
        tick(2);

        // Full-rate burst of 20 strobes; old source updates mid-fade.
        setsrc(1, 200, -200);
        sel = 3'd1;
        tick();
        gi = 1; ho_l = 0; ho_r = 0;
        for (int i = 0; i < 20; i++) begin
            vin = 6'b000010;
            if (i == 5) begin
                setsrc(0, 2000, -2000);
                vin[0] = 1'b1;
            end
            valid_in = vin;
            if (gi <= 16) begin
                exp_q.push_back(pk(mixv(ho_l, 200, gi), mixv(ho_r, -200, gi)));
                gi++;
            end else exp_q.push_back(pk(200, -200));
            if (i == 5) begin
                ho_l = 2000;
                ho_r = -2000;
            end
            tick();
            if (i >= 1) chk("burst_valid", int'(valid_out), 1);
        end
        valid_in = '0;
        tick(4);
        chk("burst_busy", int'(busy), 0);
        chk("burst_active", int'(active_src), 1);
        chk("drain_burst", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
